// File: rtl/card_addr_gen.sv
// Card-select address generator: maps VGA counters to image ROM addresses and highlights the selected slot.
// Optional blinking highlight is built when CARD_ADDR_BLINK_EN is defined.
module card_addr_gen #(
    parameter int IMG_W        = 320,
    parameter int IMG_H        = 240,
    parameter int SHIFT        = 1,
    parameter int SLOTS        = 2,
    parameter int BX           = 20,
    parameter int BY_TOP       = 60,
    parameter int BY_BOT       = 165,
    parameter int BLINK_FRAMES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  outer_state,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        frame_tick,
    input  logic [3:0]  choose,
    output logic [16:0] pixel_addr,
    output logic        hl,
    output logic [3:0]  hl_slot,
    output logic        black
);

    localparam int SLOT_W = IMG_W / SLOTS;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef enum logic {S_INIT, S_SEL} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic        w_sel_change;
    logic        w_choose_ok;
    logic [3:0]  w_req;

    logic [9:0]  w_x, w_y;
    logic [31:0] w_x32, w_y32;
    logic [31:0] w_lin, w_slot_lo, w_off;
    logic [16:0] w_base;
    logic        w_in_img, w_in_slot, w_edge, w_border;
    logic        w_black, w_phase, w_hl;
    logic [16:0] w_addr;
    logic [3:0]  w_slot;

    assign w_choose_ok = (choose != 4'd0) && ({28'd0, choose} <= 32'(SLOTS));
    assign w_req       = choose - 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_sel_change = 1'b0;
        if (outer_state == 2'd0 && w_choose_ok) begin
            w_state_nxt  = S_SEL;
            w_sel_nxt    = w_req;
            w_sel_change = (r_state == S_INIT) || (r_sel != w_req);
        end
    end

    assign w_x    = h_cnt >> SHIFT;
    assign w_y    = v_cnt >> SHIFT;
    assign w_x32  = {22'd0, w_x};
    assign w_y32  = {22'd0, w_y};
    // Wide arithmetic so the row product cannot overflow before the wrap
    assign w_lin  = w_y32 * 32'(IMG_W) + w_x32;
    assign w_base = 17'(w_lin % 32'(NPIX));

    assign w_in_img  = (w_x32 < 32'(IMG_W)) && (w_y32 < 32'(IMG_H));
    assign w_slot_lo = {28'd0, r_sel} * 32'(SLOT_W);
    assign w_off     = w_x32 - w_slot_lo;
    assign w_in_slot = (w_x32 >= w_slot_lo) && (w_x32 < w_slot_lo + 32'(SLOT_W));
    assign w_edge    = (w_off < 32'(BX)) || (w_off >= 32'(SLOT_W - BX)) ||
                       (w_y32 <= 32'(BY_TOP)) || (w_y32 >= 32'(BY_BOT));
    assign w_border  = (r_state == S_SEL) && w_in_img && w_in_slot && w_edge;

    assign w_black = (outer_state != 2'd0);
    assign w_hl    = w_border && w_phase && !w_black;
    assign w_addr  = (w_border || !w_in_img) ? '0 : w_base;
    assign w_slot  = (r_state == S_SEL) ? r_sel : '0;

`ifdef CARD_ADDR_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    // A new selection restarts the blink cycle visibly lit, overriding a coincident tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_sel_change) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (frame_tick) begin
            if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_phase = r_blink_phase;
`else
    logic w_unused;
    assign w_unused = frame_tick ^ w_sel_change;
    assign w_phase  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr <= '0;
            hl         <= 1'b0;
            hl_slot    <= '0;
            black      <= 1'b0;
        end else begin
            pixel_addr <= w_addr;
            hl         <= w_hl;
            hl_slot    <= w_slot;
            black      <= w_black;
        end
    end

endmodule
